bist_response_analyzer: RTL and testbench

Response analyzer for the 256x4b SRAM BIST. It sits at the read-data end of the march sequence: it takes the read strobe, address, and expected nibble from the march address/pattern generator, plus the data the SRAM returns. It compares every read, counts mismatches, and captures the first failing location. At end of test it reports a sticky pass/fail verdict.

---
 rtl/bist_response_analyzer_if.sv | 48 ++++
 rtl/bist_response_analyzer.sv | 220 ++++++++++++++++++++++
 tb/tb_bist_response_analyzer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_response_analyzer_if.sv
// Bus between the march generator / SRAM read path and the BIST response analyzer.
//   Generator side (master): start, rd_stb, addr, exp_data, elem, rd_data, done_in
//   Analyzer side  (slave) : busy, done, pass, fail, fail_cnt, ff_addr, ff_elem, ff_syn
//   With BIST_FAIL_LOG_EN defined, adds the fail-log read port:
//     log_rd (master) and log_valid, log_data, log_ovf (slave).
interface bist_response_analyzer_if #(
   parameter int unsigned CNT_W = 10
);
   logic             start;
   logic             rd_stb;
   logic [7:0]       addr;
   logic [3:0]       exp_data;
   logic [2:0]       elem;
   logic [3:0]       rd_data;
   logic             done_in;
   logic             busy;
   logic             done;
   logic             pass;
   logic             fail;
   logic [CNT_W-1:0] fail_cnt;
   logic [7:0]       ff_addr;
   logic [2:0]       ff_elem;
   logic [3:0]       ff_syn;
`ifdef BIST_FAIL_LOG_EN
   logic             log_valid;
   logic             log_rd;
   logic [14:0]      log_data;
   logic             log_ovf;
`endif

   modport master (
`ifdef BIST_FAIL_LOG_EN
      output log_rd,
      input  log_valid, log_data, log_ovf,
`endif
      output start, rd_stb, addr, exp_data, elem, rd_data, done_in,
      input  busy, done, pass, fail, fail_cnt, ff_addr, ff_elem, ff_syn
   );

   modport slave (
`ifdef BIST_FAIL_LOG_EN
      input  log_rd,
      output log_valid, log_data, log_ovf,
`endif
      input  start, rd_stb, addr, exp_data, elem, rd_data, done_in,
      output busy, done, pass, fail, fail_cnt, ff_addr, ff_elem, ff_syn
   );
endinterface

// File: rtl/bist_response_analyzer.sv
// Response analyzer for the 256x4b SRAM march BIST. Aligns each accepted read
// strobe with the SRAM data RD_LAT cycles later, compares, counts mismatches
// (saturating), captures the first failing address/element/syndrome and reports
// a sticky pass/fail verdict once the generator signals completion.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - bist_response_analyzer_if.slave (strobe/address/expected/element in,
//          SRAM read data in, verdict and first-fail capture out)
// Optional feature macro: BIST_FAIL_LOG_EN adds a LOG_DEPTH-entry fail-log FIFO
// ({elem, addr, syn} per entry) with pop port and sticky overflow flag.
module bist_response_analyzer #(
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned CNT_W     = 10,
   parameter int unsigned LOG_DEPTH = 8
) (
   input logic                     clk,
   input logic                     rst,
   bist_response_analyzer_if.slave bus
);
   localparam int unsigned DRN_W = 3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   // Read tag that travels alongside the SRAM access.
   typedef struct packed {
      logic       vld;
      logic [2:0] elem;
      logic [7:0] addr;
      logic [3:0] exp;
   } tag_t;

   // Elaboration-time parameter sanity.
   if (RD_LAT > 4) begin : g_bad_lat
      $error("bist_response_analyzer: RD_LAT must be 0..4");
   end
   if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bist_response_analyzer: LOG_DEPTH must be a power of two >= 2");
   end

   state_t           state, state_nxt;
   logic [DRN_W-1:0] drn_cnt;
   logic             drn_last;
   logic             busy_q, done_q, pass_q;
   logic             busy_nxt, done_nxt, pass_nxt;
   tag_t             tag_in, tag_cmp;
   logic [3:0]       syn;
   logic             mismatch;
   logic             fail_q, fail_nxt;
   logic [CNT_W-1:0] fail_cnt_q;
   logic [7:0]       ff_addr_q;
   logic [2:0]       ff_elem_q;
   logic [3:0]       ff_syn_q;

   // FSM state register; verdict flags are registered from next-state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         pass_q <= pass_nxt;
      end
   end

   // Next-state logic; start overrides everything, including done_in.
   always_comb begin
      state_nxt = state;
      if (bus.start) begin
         state_nxt = S_RUN;
      end else begin
         case (state)
            S_RUN:   if (bus.done_in) state_nxt = S_DRAIN;
            S_DRAIN: if (drn_last)    state_nxt = S_DONE;
            default: ;
         endcase
      end
   end

   // Output decode for the cycle after this edge.
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      pass_nxt = 1'b0;
      case (state_nxt)
         S_RUN, S_DRAIN: busy_nxt = 1'b1;
         S_DONE: begin
            done_nxt = 1'b1;
            pass_nxt = !fail_nxt;
         end
         default: ;
      endcase
   end

   // DRAIN lasts RD_LAT+1 cycles so every in-flight compare lands first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  drn_cnt <= '0;
      else if (state != S_DRAIN) drn_cnt <= '0;
      else                      drn_cnt <= drn_cnt + DRN_W'(1);
   end
   assign drn_last = (drn_cnt == DRN_W'(RD_LAT));

   // Strobes count only in RUN; the start cycle itself is not a test read.
   always_comb begin
      tag_in      = '0;
      tag_in.vld  = bus.rd_stb && (state == S_RUN) && !bus.start;
      tag_in.elem = bus.elem;
      tag_in.addr = bus.addr;
      tag_in.exp  = bus.exp_data;
   end

   // Tag delay line matching the SRAM read latency.
   if (RD_LAT == 0) begin : g_nolat
      assign tag_cmp = tag_in;
   end else begin : g_lat
      tag_t pipe_q [RD_LAT];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= bus.start ? '0 : pipe_q[i-1];
         end
      end
      assign tag_cmp = pipe_q[RD_LAT-1];
   end

   assign syn      = bus.rd_data ^ tag_cmp.exp;
   assign mismatch = tag_cmp.vld && (syn != 4'b0000);
   assign fail_nxt = !bus.start && (fail_q || mismatch);

   // Mismatch count and first-fail capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_q     <= 1'b0;
         fail_cnt_q <= '0;
         ff_addr_q  <= '0;
         ff_elem_q  <= '0;
         ff_syn_q   <= '0;
      end else if (bus.start) begin
         fail_q     <= 1'b0;
         fail_cnt_q <= '0;
         ff_addr_q  <= '0;
         ff_elem_q  <= '0;
         ff_syn_q   <= '0;
      end else if (mismatch) begin
         if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
         if (!fail_q) begin
            fail_q    <= 1'b1;
            ff_addr_q <= tag_cmp.addr;
            ff_elem_q <= tag_cmp.elem;
            ff_syn_q  <= syn;
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.fail     = fail_q;
   assign bus.fail_cnt = fail_cnt_q;
   assign bus.ff_addr  = ff_addr_q;
   assign bus.ff_elem  = ff_elem_q;
   assign bus.ff_syn   = ff_syn_q;

`ifdef BIST_FAIL_LOG_EN
   localparam int unsigned PTR_W  = $clog2(LOG_DEPTH);
   localparam int unsigned LCNT_W = PTR_W + 1;
   localparam int unsigned ENT_W  = 15;

   logic [ENT_W-1:0]  log_mem [LOG_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LCNT_W-1:0] log_cnt;
   logic              log_ovf_q, log_vld, log_full, log_push, log_pop, log_wr;

   assign log_vld  = (log_cnt != '0);
   assign log_full = (log_cnt == LCNT_W'(LOG_DEPTH));
   assign log_pop  = bus.log_rd && log_vld;
   assign log_push = mismatch && !bus.start;
   // When full, a push only lands if the head leaves in the same cycle.
   assign log_wr   = log_push && (!log_full || log_pop);

   // Fail-log pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         log_cnt   <= '0;
         log_ovf_q <= 1'b0;
      end else if (bus.start) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         log_cnt   <= '0;
         log_ovf_q <= 1'b0;
      end else begin
         if (log_wr)             wr_ptr    <= wr_ptr + PTR_W'(1);
         if (log_pop)            rd_ptr    <= rd_ptr + PTR_W'(1);
         if (log_push && !log_wr) log_ovf_q <= 1'b1;
         case ({log_wr, log_pop})
            2'b10:   log_cnt <= log_cnt + LCNT_W'(1);
            2'b01:   log_cnt <= log_cnt - LCNT_W'(1);
            default: ;
         endcase
      end
   end

   // Fail-log storage.
   always_ff @(posedge clk) begin
      if (log_wr) log_mem[wr_ptr] <= {tag_cmp.elem, tag_cmp.addr, syn};
   end

   assign bus.log_valid = log_vld;
   assign bus.log_data  = log_vld ? log_mem[rd_ptr] : '0;
   assign bus.log_ovf   = log_ovf_q;
`endif
endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench: four analyzers (RD_LAT 0, 1, 2, 4) share one stimulus stream;
// a stuck-at-1 SRAM model supplies rd_data delayed by each instance's latency.
module tb_bist_response_analyzer;
   localparam int unsigned CNT_W = 10;
   localparam int          NDUT  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start, rd_stb, done_in;
   logic [7:0] addr;
   logic [3:0] exp_data;
   logic [2:0] elem;

   logic [3:0] s1 [256];
   logic [3:0] resp0;
   logic [3:0] rdq [1:4];

   logic [NDUT-1:0]  busy_v, done_v, pass_v, fail_v;
   logic [CNT_W-1:0] cnt_v [NDUT];
   logic [7:0]       ffa_v [NDUT];
   logic [2:0]       ffe_v [NDUT];
   logic [3:0]       ffs_v [NDUT];
`ifdef BIST_FAIL_LOG_EN
   logic             log_rd;
   logic [NDUT-1:0]  lv_v, lovf_v;
   logic [14:0]      ld_v [NDUT];
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // SRAM with stuck-at-1 bits; stored data equals the expected pattern.
   assign resp0 = exp_data | s1[addr];
   always @(posedge clk) begin
      rdq[1] <= resp0;
      rdq[2] <= rdq[1];
      rdq[3] <= rdq[2];
      rdq[4] <= rdq[3];
   end

   for (genvar j = 0; j < NDUT; j++) begin : g_dut
      localparam int unsigned L = (j == 3) ? 4 : j;
      bist_response_analyzer_if #(.CNT_W(CNT_W)) bus ();
      assign bus.start    = start;
      assign bus.rd_stb   = rd_stb;
      assign bus.addr     = addr;
      assign bus.exp_data = exp_data;
      assign bus.elem     = elem;
      assign bus.done_in  = done_in;
      if (L == 0) begin : g_l0
         assign bus.rd_data = resp0;
      end else begin : g_ln
         assign bus.rd_data = rdq[L];
      end
      assign busy_v[j] = bus.busy;
      assign done_v[j] = bus.done;
      assign pass_v[j] = bus.pass;
      assign fail_v[j] = bus.fail;
      assign cnt_v[j]  = bus.fail_cnt;
      assign ffa_v[j]  = bus.ff_addr;
      assign ffe_v[j]  = bus.ff_elem;
      assign ffs_v[j]  = bus.ff_syn;
`ifdef BIST_FAIL_LOG_EN
      assign bus.log_rd = log_rd;
      assign lv_v[j]    = bus.log_valid;
      assign lovf_v[j]  = bus.log_ovf;
      assign ld_v[j]    = bus.log_data;
`endif
      bist_response_analyzer #(.RD_LAT(L), .CNT_W(CNT_W), .LOG_DEPTH(8)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   function automatic int lat(input int j);
      return (j == 3) ? 4 : j;
   endfunction

   function automatic string tg(input string s, input int j);
      return $sformatf("%s_L%0d", s, lat(j));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic strobe(input logic [7:0] a, input logic [3:0] e, input logic [2:0] el);
      rd_stb   = 1'b1;
      addr     = a;
      exp_data = e;
      elem     = el;
      tick();
      rd_stb   = 1'b0;
   endtask

   task automatic chk_zero(input string ph);
      for (int j = 0; j < NDUT; j++) begin
         chk(tg({ph, "_busy"}, j), 32'(busy_v[j]), 32'd0);
         chk(tg({ph, "_done"}, j), 32'(done_v[j]), 32'd0);
         chk(tg({ph, "_pass"}, j), 32'(pass_v[j]), 32'd0);
         chk(tg({ph, "_fail"}, j), 32'(fail_v[j]), 32'd0);
         chk(tg({ph, "_cnt"}, j),  32'(cnt_v[j]),  32'd0);
         chk(tg({ph, "_ffa"}, j),  32'(ffa_v[j]),  32'd0);
         chk(tg({ph, "_ffe"}, j),  32'(ffe_v[j]),  32'd0);
         chk(tg({ph, "_ffs"}, j),  32'(ffs_v[j]),  32'd0);
`ifdef BIST_FAIL_LOG_EN
         chk(tg({ph, "_lv"}, j),   32'(lv_v[j]),   32'd0);
         chk(tg({ph, "_lovf"}, j), 32'(lovf_v[j]), 32'd0);
         chk(tg({ph, "_ld"}, j),   32'(ld_v[j]),   32'd0);
`endif
      end
   endtask

   // done_in in the current cycle d (any strobe already set up stays for d only);
   // done must rise exactly at d+RD_LAT+2 and busy fall with it.
   task automatic finish_run(input string ph, input logic ep, input logic ef, input int unsigned ec);
      done_in = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         done_in = 1'b0;
         rd_stb  = 1'b0;
         for (int j = 0; j < NDUT; j++) begin
            chk(tg($sformatf("%s_done_k%0d", ph, k), j), 32'(done_v[j]), 32'(k >= lat(j) + 2));
            chk(tg($sformatf("%s_busy_k%0d", ph, k), j), 32'(busy_v[j]), 32'(k < lat(j) + 2));
         end
      end
      for (int j = 0; j < NDUT; j++) begin
         chk(tg({ph, "_pass"}, j), 32'(pass_v[j]), 32'(ep));
         chk(tg({ph, "_fail"}, j), 32'(fail_v[j]), 32'(ef));
         chk(tg({ph, "_cnt"}, j),  32'(cnt_v[j]),  ec);
      end
   endtask

   initial begin
      start = 1'b0; rd_stb = 1'b0; done_in = 1'b0;
      addr = '0; exp_data = '0; elem = '0;
`ifdef BIST_FAIL_LOG_EN
      log_rd = 1'b0;
`endif
      for (int a = 0; a < 256; a++) s1[a] = 4'b0000;

      // Reset state
      tick(); tick();
      chk_zero("rst");
      rst = 1'b0;
      tick();
      for (int j = 0; j < NDUT; j++) chk(tg("idle_busy", j), 32'(busy_v[j]), 32'd0);

      // Clean march: 1280 back-to-back reads
      pulse_start();
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("arm_busy", j), 32'(busy_v[j]), 32'd1);
         chk(tg("arm_done", j), 32'(done_v[j]), 32'd0);
      end
      for (int i = 0; i < 1280; i++) strobe(8'(i), 4'(i ^ (i >> 8)), 3'(i / 256));
      finish_run("clean", 1'b1, 1'b0, 0);

      // Stuck-at-1 on bit 2 of 0x3A, exposed only by the all-zero element
      s1[8'h3A] = 4'b0100;
      pulse_start();
      for (int i = 0; i < 256; i++) strobe(8'(i), 4'hF, 3'd0);
      for (int i = 0; i < 256; i++) begin
         strobe(8'(i), 4'h0, 3'd1);
         if (i >= 8'h3A && i <= 8'h3F) begin
            for (int j = 0; j < NDUT; j++) begin
               chk(tg($sformatf("stk_fail_k%0d", i - 8'h3A + 1), j), 32'(fail_v[j]),
                   32'((i - 8'h3A + 1) >= lat(j) + 1));
               chk(tg($sformatf("stk_cnt_k%0d", i - 8'h3A + 1), j), 32'(cnt_v[j]),
                   32'((i - 8'h3A + 1) >= lat(j) + 1));
            end
         end
      end
      finish_run("stk", 1'b0, 1'b1, 1);
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("stk_ffa", j), 32'(ffa_v[j]), 32'h3A);
         chk(tg("stk_ffe", j), 32'(ffe_v[j]), 32'd1);
         chk(tg("stk_ffs", j), 32'(ffs_v[j]), 32'b0100);
      end
      s1[8'h3A] = 4'b0000;

      // Ten mismatches at 0x00..0x09
      for (int a = 0; a < 10; a++) s1[a] = 4'b0001;
      pulse_start();
      for (int i = 0; i < 16; i++) strobe(8'(i), 4'h0, 3'd2);
      finish_run("ten", 1'b0, 1'b1, 10);
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("ten_ffa", j), 32'(ffa_v[j]), 32'h00);
         chk(tg("ten_ffe", j), 32'(ffe_v[j]), 32'd2);
         chk(tg("ten_ffs", j), 32'(ffs_v[j]), 32'b0001);
      end
`ifdef BIST_FAIL_LOG_EN
      for (int j = 0; j < NDUT; j++) chk(tg("ten_ovf", j), 32'(lovf_v[j]), 32'd1);
      for (int p = 0; p < 8; p++) begin
         logic [7:0]  pa;
         logic [14:0] ent;
         pa  = 8'(p);
         ent = {3'd2, pa, 4'b0001};
         for (int j = 0; j < NDUT; j++) begin
            chk(tg($sformatf("pop%0d_vld", p), j), 32'(lv_v[j]), 32'd1);
            chk(tg($sformatf("pop%0d_data", p), j), 32'(ld_v[j]), 32'(ent));
         end
         log_rd = 1'b1;
         tick();
         log_rd = 1'b0;
      end
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("pop_empty", j), 32'(lv_v[j]), 32'd0);
         chk(tg("pop_ld0", j),   32'(ld_v[j]), 32'd0);
      end
`endif
      for (int a = 0; a < 10; a++) s1[a] = 4'b0000;

      // done_in coincident with the final (failing) strobe
      s1[8'h0F] = 4'b1000;
      pulse_start();
`ifdef BIST_FAIL_LOG_EN
      for (int j = 0; j < NDUT; j++) chk(tg("start_ovf_clr", j), 32'(lovf_v[j]), 32'd0);
`endif
      for (int i = 0; i < 15; i++) strobe(8'(i), 4'h0, 3'd3);
      rd_stb = 1'b1; addr = 8'h0F; exp_data = 4'h0; elem = 3'd3;
      finish_run("last", 1'b0, 1'b1, 1);
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("last_ffa", j), 32'(ffa_v[j]), 32'h0F);
         chk(tg("last_ffs", j), 32'(ffs_v[j]), 32'b1000);
      end
      s1[8'h0F] = 4'b0000;

      // Counter saturation: 1030 failing reads
      for (int a = 0; a < 256; a++) s1[a] = 4'hF;
      pulse_start();
      for (int i = 0; i < 1030; i++) strobe(8'(i), 4'h0, 3'd5);
      finish_run("sat", 1'b0, 1'b1, 1023);
      for (int j = 0; j < NDUT; j++) chk(tg("sat_ffs", j), 32'(ffs_v[j]), 32'hF);
      for (int a = 0; a < 256; a++) s1[a] = 4'b0000;

      // Reset mid-RUN with compares in flight
      for (int a = 8'h20; a < 8'h30; a++) s1[a] = 4'hF;
      pulse_start();
      for (int i = 8'h20; i < 8'h24; i++) strobe(8'(i), 4'h0, 3'd6);
      chk("pre_rst_fail_L1", 32'(fail_v[1]), 32'd1);
      rst = 1'b1;
      #1;
      chk_zero("arst");
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk_zero("post_rst");
      for (int a = 8'h20; a < 8'h30; a++) s1[a] = 4'b0000;
      pulse_start();
      for (int i = 0; i < 16; i++) strobe(8'(i), 4'(i), 3'd0);
      finish_run("rerun", 1'b1, 1'b0, 0);

      // Strobe in DONE is ignored
      s1[8'h50] = 4'hF;
      strobe(8'h50, 4'h0, 3'd0);
      for (int k = 0; k < 5; k++) tick();
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("dstb_fail", j), 32'(fail_v[j]), 32'd0);
         chk(tg("dstb_cnt", j),  32'(cnt_v[j]),  32'd0);
         chk(tg("dstb_done", j), 32'(done_v[j]), 32'd1);
         chk(tg("dstb_pass", j), 32'(pass_v[j]), 32'd1);
      end

      // start coinciding with done_in, from DONE and then from RUN
      pulse_start();
      strobe(8'h50, 4'h0, 3'd4);
      finish_run("pre", 1'b0, 1'b1, 1);
      start = 1'b1; done_in = 1'b1;
      tick();
      start = 1'b0; done_in = 1'b0;
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("co_busy", j), 32'(busy_v[j]), 32'd1);
         chk(tg("co_done", j), 32'(done_v[j]), 32'd0);
         chk(tg("co_pass", j), 32'(pass_v[j]), 32'd0);
         chk(tg("co_fail", j), 32'(fail_v[j]), 32'd0);
         chk(tg("co_cnt", j),  32'(cnt_v[j]),  32'd0);
         chk(tg("co_ffa", j),  32'(ffa_v[j]),  32'd0);
         chk(tg("co_ffe", j),  32'(ffe_v[j]),  32'd0);
         chk(tg("co_ffs", j),  32'(ffs_v[j]),  32'd0);
      end
      start = 1'b1; done_in = 1'b1;
      tick();
      start = 1'b0; done_in = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      for (int j = 0; j < NDUT; j++) begin
         chk(tg("co_run_busy", j), 32'(busy_v[j]), 32'd1);
         chk(tg("co_run_done", j), 32'(done_v[j]), 32'd0);
      end
      s1[8'h50] = 4'b0000;
      finish_run("empty", 1'b1, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
